// File: rtl/r_config_send_if.sv
// Handshake bundle between an R-configuration requester, the sender and the receiver's storage.
// master drives the request side; slave is the sender itself.
interface r_config_send_if #(
  parameter int WIDTH_DATA = 32
);
  logic                  I_Start;
  logic [WIDTH_DATA-1:0] I_RConfig;
  logic [WIDTH_DATA-1:0] I_Length;
  logic [WIDTH_DATA-1:0] I_Stride;
  logic [WIDTH_DATA-1:0] I_Base;
  logic                  I_Stall;
  logic                  I_Abort;
  logic                  O_We;
  logic [WIDTH_DATA-1:0] O_Data;
  logic                  O_Clr;
  logic                  O_Busy;
  logic                  O_End_RConfig;

  modport master (
    output I_Start, I_RConfig, I_Length, I_Stride, I_Base, I_Stall, I_Abort,
    input  O_We, O_Data, O_Clr, O_Busy, O_End_RConfig
  );

  modport slave (
    input  I_Start, I_RConfig, I_Length, I_Stride, I_Base, I_Stall, I_Abort,
    output O_We, O_Data, O_Clr, O_Busy, O_End_RConfig
  );
endinterface

// File: rtl/r_config_send.sv
// Sends a latched 4-word R-configuration (RConfig, Length, Stride, Base) to the receiver's storage.
// Optional abort support is enabled by defining RCONFIG_SEND_ABORT_EN.
module r_config_send #(
  parameter int WIDTH_DATA = 32
) (
  input  logic             clock,
  input  logic             reset,
  r_config_send_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [1:0]            r_cnt;
  logic [WIDTH_DATA-1:0] r_config;
  logic [WIDTH_DATA-1:0] r_length;
  logic [WIDTH_DATA-1:0] r_stride;
  logic [WIDTH_DATA-1:0] r_base;
  logic [WIDTH_DATA-1:0] data_sel;
  logic                  abort_hit;
  logic                  word_issue;

`ifdef RCONFIG_SEND_ABORT_EN
  assign abort_hit = bus.I_Abort & (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Abort outranks stall: an aborted cycle never issues a word.
  assign word_issue = (state == SEND) & ~bus.I_Stall & ~abort_hit;

  // NOTE: the field registers are ordinary flops, so they take the async reset too;
  // every sequential assignment is non-blocking so all state updates see pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      r_cnt    <= 2'd0;
      r_config <= '0;
      r_length <= '0;
      r_stride <= '0;
      r_base   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.I_Start) begin
            r_config <= bus.I_RConfig;
            r_length <= bus.I_Length;
            r_stride <= bus.I_Stride;
            r_base   <= bus.I_Base;
            r_cnt    <= 2'd0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (abort_hit) begin
            r_cnt <= 2'd0;
            state <= IDLE;
          end else if (word_issue) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) state <= DONE;
          end
        end
        DONE: begin
          r_cnt <= 2'd0;
          state <= IDLE;
        end
        default: begin
          r_cnt <= 2'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  // NOTE: the default assignment up front keeps this mux free of inferred latches.
  always_comb begin
    data_sel = '0;
    if (state == SEND) begin
      case (r_cnt)
        2'd0:    data_sel = r_config;
        2'd1:    data_sel = r_length;
        2'd2:    data_sel = r_stride;
        default: data_sel = r_base;
      endcase
    end
  end

  assign bus.O_We          = word_issue;
  assign bus.O_Data        = data_sel;
  assign bus.O_Clr         = abort_hit;
  assign bus.O_Busy        = (state != IDLE);
  assign bus.O_End_RConfig = (state == DONE) & ~abort_hit;

endmodule

// File: tb/tb_r_config_send.sv
// Directed bench for r_config_send: queue-based sender model, receiver storage loopback,
// and literal per-cycle expectations. Honours RCONFIG_SEND_ABORT_EN like the design.
module tb_r_config_send;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  r_config_send_if #(.WIDTH_DATA(32)) bus ();

  r_config_send #(.WIDTH_DATA(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Receiver storage: captures accepted words, clears on O_Clr, flags end after the 4th word.
  logic [31:0] rx_mem [4];
  logic [1:0]  rx_cnt;
  logic        rx_end;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_cnt <= 2'd0;
      rx_end <= 1'b0;
      for (int i = 0; i < 4; i++) rx_mem[i] <= '0;
    end else begin
      rx_end <= 1'b0;
      if (bus.O_Clr) begin
        rx_cnt <= 2'd0;
      end else if (bus.O_We) begin
        rx_mem[rx_cnt] <= bus.O_Data;
        rx_cnt         <= rx_cnt + 2'd1;
        if (rx_cnt == 2'd3) rx_end <= 1'b1;
      end
    end
  end

  // Per-cycle log of DUT outputs for the literal expectations.
  logic        we_log   [1024];
  logic [31:0] data_log [1024];
  logic        clr_log  [1024];
  logic        busy_log [1024];
  logic        end_log  [1024];

  // Model: words still owed to the receiver, plus a pending end pulse.
  logic [31:0] mq [$];
  bit          end_due = 1'b0;

  always @(negedge clock) begin
    logic        e_busy, e_abort, e_we, e_end;
    logic [31:0] e_data;
    we_log[cyc % 1024]   = bus.O_We;
    data_log[cyc % 1024] = bus.O_Data;
    clr_log[cyc % 1024]  = bus.O_Clr;
    busy_log[cyc % 1024] = bus.O_Busy;
    end_log[cyc % 1024]  = bus.O_End_RConfig;
    if (reset) begin
      check("rst_we",   {31'd0, bus.O_We},          32'd0);
      check("rst_data", bus.O_Data,                 32'd0);
      check("rst_clr",  {31'd0, bus.O_Clr},         32'd0);
      check("rst_busy", {31'd0, bus.O_Busy},        32'd0);
      check("rst_end",  {31'd0, bus.O_End_RConfig}, 32'd0);
      mq.delete();
      end_due = 1'b0;
    end else begin
      e_busy = (mq.size() > 0) || end_due;
`ifdef RCONFIG_SEND_ABORT_EN
      e_abort = e_busy && bus.I_Abort;
`else
      e_abort = 1'b0;
`endif
      e_we   = (mq.size() > 0) && !bus.I_Stall && !e_abort;
      e_data = (mq.size() > 0) ? mq[0] : 32'd0;
      e_end  = end_due && !e_abort;
      check("we",     {31'd0, bus.O_We},          {31'd0, e_we});
      check("data",   bus.O_Data,                 e_data);
      check("clr",    {31'd0, bus.O_Clr},         {31'd0, e_abort});
      check("busy",   {31'd0, bus.O_Busy},        {31'd0, e_busy});
      check("end",    {31'd0, bus.O_End_RConfig}, {31'd0, e_end});
      check("rx_end", {31'd0, rx_end},            {31'd0, e_end});
      if (e_abort) begin
        mq.delete();
        end_due = 1'b0;
      end else if (end_due) begin
        end_due = 1'b0;
      end else if (mq.size() > 0) begin
        if (e_we) begin
          void'(mq.pop_front());
          if (mq.size() == 0) end_due = 1'b1;
        end
      end else if (bus.I_Start) begin
        mq.push_back(bus.I_RConfig);
        mq.push_back(bus.I_Length);
        mq.push_back(bus.I_Stride);
        mq.push_back(bus.I_Base);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fields(input logic [31:0] a, b, c, d);
    bus.I_RConfig = a;
    bus.I_Length  = b;
    bus.I_Stride  = c;
    bus.I_Base    = d;
  endtask

  function automatic logic [31:0] lw(input int k);
    return {31'd0, we_log[k % 1024]};
  endfunction
  function automatic logic [31:0] ld(input int k);
    return data_log[k % 1024];
  endfunction
  function automatic logic [31:0] le(input int k);
    return {31'd0, end_log[k % 1024]};
  endfunction
  function automatic logic [31:0] lb(input int k);
    return {31'd0, busy_log[k % 1024]};
  endfunction
  function automatic logic [31:0] lc(input int k);
    return {31'd0, clr_log[k % 1024]};
  endfunction

  initial begin
    int t;
    int n_end;
    bus.I_Start = 1'b0;
    bus.I_Stall = 1'b0;
    bus.I_Abort = 1'b0;
    set_fields(32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state
    tick(); tick();
    check("reset_we",   {31'd0, bus.O_We},          32'd0);
    check("reset_busy", {31'd0, bus.O_Busy},        32'd0);
    check("reset_data", bus.O_Data,                 32'd0);
    #2 reset = 1'b0;
    tick();

    // Basic send, fields changed right after the start
    set_fields(32'hA1, 32'hB2, 32'hC3, 32'hD4);
    t = cyc; bus.I_Start = 1'b1; tick(); bus.I_Start = 1'b0;
    set_fields(32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004);
    repeat (7) tick();
    check("basic_we0",   lw(t),   32'd0);
    check("basic_d1",    ld(t+1), 32'hA1);
    check("basic_d2",    ld(t+2), 32'hB2);
    check("basic_d3",    ld(t+3), 32'hC3);
    check("basic_d4",    ld(t+4), 32'hD4);
    check("basic_we4",   lw(t+4), 32'd1);
    check("basic_end4",  le(t+4), 32'd0);
    check("basic_end5",  le(t+5), 32'd1);
    check("basic_busy5", lb(t+5), 32'd1);
    check("basic_end6",  le(t+6), 32'd0);
    check("basic_busy6", lb(t+6), 32'd0);
    check("loop_f0", rx_mem[0], 32'hA1);
    check("loop_f1", rx_mem[1], 32'hB2);
    check("loop_f2", rx_mem[2], 32'hC3);
    check("loop_f3", rx_mem[3], 32'hD4);

    // Two stall cycles on the second word
    set_fields(32'hA1, 32'hB2, 32'hC3, 32'hD4);
    t = cyc; bus.I_Start = 1'b1; tick(); bus.I_Start = 1'b0;
    tick(); bus.I_Stall = 1'b1; tick(); tick(); bus.I_Stall = 1'b0;
    repeat (6) tick();
    check("stall_we2",  lw(t+2), 32'd0);
    check("stall_d2",   ld(t+2), 32'hB2);
    check("stall_d3",   ld(t+3), 32'hB2);
    check("stall_we4",  lw(t+4), 32'd1);
    check("stall_d5",   ld(t+5), 32'hC3);
    check("stall_d6",   ld(t+6), 32'hD4);
    check("stall_end6", le(t+6), 32'd0);
    check("stall_end7", le(t+7), 32'd1);

    // Start held high: back-to-back sequences, fields changed mid-sequence
    set_fields(32'hA1, 32'hB2, 32'hC3, 32'hD4);
    t = cyc; bus.I_Start = 1'b1; tick(); tick();
    set_fields(32'h11, 32'h22, 32'h33, 32'h44);
    repeat (10) tick();
    bus.I_Start = 1'b0;
    repeat (4) tick();
    check("b2b_d1",    ld(t+1),  32'hA1);
    check("b2b_d4",    ld(t+4),  32'hD4);
    check("b2b_end5",  le(t+5),  32'd1);
    check("b2b_busy6", lb(t+6),  32'd0);
    check("b2b_d7",    ld(t+7),  32'h11);
    check("b2b_d10",   ld(t+10), 32'h44);
    check("b2b_end11", le(t+11), 32'd1);
    check("b2b_busy12", lb(t+12), 32'd0);

    // Abort on the second word
    set_fields(32'hA1, 32'hB2, 32'hC3, 32'hD4);
    t = cyc; bus.I_Start = 1'b1; tick(); bus.I_Start = 1'b0;
    tick(); bus.I_Abort = 1'b1; tick(); bus.I_Abort = 1'b0;
    repeat (6) tick();
    n_end = 0;
    for (int k = 1; k <= 8; k++) n_end += int'(end_log[(t+k) % 1024]);
`ifdef RCONFIG_SEND_ABORT_EN
    check("abort_we2",   lw(t+2), 32'd0);
    check("abort_clr2",  lc(t+2), 32'd1);
    check("abort_busy3", lb(t+3), 32'd0);
    check("abort_noend", n_end,   32'd0);
`else
    check("noabort_d2",   ld(t+2), 32'hB2);
    check("noabort_clr2", lc(t+2), 32'd0);
    check("noabort_d4",   ld(t+4), 32'hD4);
    check("noabort_end",  n_end,   32'd1);
`endif

    // Abort together with stall, then abort while idle (model-checked)
    t = cyc; bus.I_Start = 1'b1; tick(); bus.I_Start = 1'b0;
    tick(); bus.I_Stall = 1'b1; bus.I_Abort = 1'b1; tick();
    bus.I_Stall = 1'b0; bus.I_Abort = 1'b0;
    repeat (7) tick();
    bus.I_Abort = 1'b1; repeat (3) tick(); bus.I_Abort = 1'b0;
    tick();

    // Reset between edges after the third word
    set_fields(32'hA1, 32'hB2, 32'hC3, 32'hD4);
    t = cyc; bus.I_Start = 1'b1; tick(); bus.I_Start = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_we",   {31'd0, bus.O_We},          32'd0);
    check("midrst_data", bus.O_Data,                 32'd0);
    check("midrst_busy", {31'd0, bus.O_Busy},        32'd0);
    check("midrst_end",  {31'd0, bus.O_End_RConfig}, 32'd0);
    @(posedge clock); #3 reset = 1'b0;
    repeat (4) tick();
    n_end = 0;
    for (int k = 4; k <= 8; k++) n_end += int'(end_log[(t+k) % 1024]);
    check("midrst_noend", n_end, 32'd0);

    set_fields(32'h5A, 32'h6B, 32'h7C, 32'h8D);
    t = cyc; bus.I_Start = 1'b1; tick(); bus.I_Start = 1'b0;
    repeat (7) tick();
    check("rerun_d1",   ld(t+1), 32'h5A);
    check("rerun_d4",   ld(t+4), 32'h8D);
    check("rerun_end5", le(t+5), 32'd1);
    check("rerun_rx0",  rx_mem[0], 32'h5A);
    check("rerun_rx3",  rx_mem[3], 32'h8D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
